weight_load_sched: RTL and testbench
====================================

Name: weight_load_sched

Overview:
- Sequences weight loading for the 16-lane PE array in the accelerator.
- On each PE request, reads one group of WORDS_PER_GROUP packed words from the weight ROM and unpacks them into 16 weight lanes.
- Presents the group with a valid/ack handshake and tracks per-output-channel weight-valid flags.
- Covers one layer pass of NUM_GROUPS groups, then reports done until restarted.

Parameters:
- ADDR_WIDTH, 7, weight ROM address width.
- WEIGHT_WIDTH, 7, bits per weight.
- LANES_PER_WORD, 4, weights packed per ROM word; DATA_WIDTH = LANES_PER_WORD*WEIGHT_WIDTH.
- WORDS_PER_GROUP, 4, ROM words per group; lanes = 16.
- NUM_GROUPS, 32, groups (output channels) per layer pass.
- ROM_LATENCY, 1, cycles from rom_en/rom_addr sample to rom_data valid (≥1).

Ports:
- clk  in  1  system clock
- rst_n  in  1  async active-low reset
- start  in  1  pulse; begin/restart a layer pass
- base_addr  in  ADDR_WIDTH  first ROM word of the pass, sampled on start
- load_req  in  1  PE requests next group
- rom_en  out  1  ROM read enable
- rom_addr  out  ADDR_WIDTH  ROM word address
- rom_data  in  DATA_WIDTH  ROM read data
- w_bus  out  16*WEIGHT_WIDTH  lane k at bits [k*7+6:k*7]
- w_valid  out  1  w_bus holds a complete group
- w_ack  in  1  PE consumed w_bus
- group_idx  out  5  index of current/next group
- new_weight_val  out  NUM_GROUPS  thermometer of delivered groups
- busy  out  1  READ or WAIT state
- done  out  1  all groups delivered

Behaviour:
- Reset is asynchronous and active-low on rst_n; everything is single-clock on clk.
- Reset values: every output 0, state IDLE. Internally: base 0, group 0, word counter 0, capture pipeline cleared.
- FSM states: IDLE, READ, WAIT, VALID, DONE.
- IDLE: load_req=1 at edge E0 moves to READ.
- READ: lasts WORDS_PER_GROUP cycles.
  - rom_en=1 (registered).
  - rom_addr = base + group_idx*WORDS_PER_GROUP + k, for k = 0..3, one per cycle.
  - Address arithmetic is mod 2^ADDR_WIDTH; wrap is silent.
  - Then enters WAIT with rom_en=0.
- Capture:
  - Each issued read is tracked through a ROM_LATENCY-deep valid pipeline.
  - When word k emerges, lanes 4k..4k+3 are loaded: rom_data[27:21] to lane 4k, [20:14] to 4k+1, [13:7] to 4k+2, [6:0] to 4k+3.
  - Lanes not yet loaded in the current group keep their previous values.
- WAIT: at the edge capturing the last word, w_valid is set and the FSM enters VALID.
  - Latency: w_valid rises at edge E0+WORDS_PER_GROUP+ROM_LATENCY (E5 with defaults).
- VALID: w_valid and w_bus hold stable until w_valid&w_ack at an edge. At that edge:
  - w_valid clears.
  - new_weight_val shifts left inserting 1.
  - If group_idx == NUM_GROUPS-1, enter DONE with done=1; group_idx holds.
  - Otherwise group_idx+1 and enter IDLE.
- DONE: done stays high until start or reset.
- busy = 1 in READ and WAIT only.
- load_req outside IDLE is ignored, not queued; the PE must re-request.
- w_ack without w_valid is ignored.
- start, in any state:
  - Next state is IDLE.
  - Clears group_idx, new_weight_val, w_valid and done.
  - Drops rom_en and flushes the capture pipeline, so in-flight ROM data is discarded.
  - Samples base_addr.
  - w_bus is not cleared.
  - start wins over a simultaneous load_req or w_ack; both are dropped.
- load_req in the cycle after start is accepted normally.
- Async reset mid-read: immediate return to reset values, with no further rom_en pulses.

Test Plan:
- Reset, then start with base_addr=0, then load_req.
  - rom_en high for 4 cycles with rom_addr 0,1,2,3.
  - w_valid rises 5 edges after acceptance.
  - With ROM word n = {4n, 4n+1, 4n+2, 4n+3} (7-bit each), w_bus lane k = k.
- Hold w_ack=0 for 10 cycles after w_valid: w_bus and w_valid stay stable. Then w_ack=1 for one cycle: w_valid drops, group_idx=1, new_weight_val=1.
- Full pass of 32 load_req/w_ack cycles with base_addr=0.
  - Last reads hit addresses 124..127.
  - new_weight_val = 0xFFFFFFFF and done=1.
  - A further load_req produces no rom_en.
- start with base_addr=126 and one group: rom_addr sequence 126, 127, 0, 1 (wrap).
- start asserted during the 3rd READ cycle:
  - rom_en drops the next cycle and w_valid never rises.
  - A following load_req reads from the new base with clean lanes 0..15.
- load_req pulsed during READ and VALID: ignored. Only one group is loaded; group_idx advances by exactly 1 per w_ack.

Source files
------------

// File: rtl/weight_load_sched.sv
// Weight-load sequencer: fetches one group of packed ROM words per PE request,
// unpacks them into the lane bus and hands the group over with a valid/ack handshake.
module weight_load_sched #(
  parameter int ADDR_WIDTH      = 7,
  parameter int WEIGHT_WIDTH    = 7,
  parameter int LANES_PER_WORD  = 4,
  parameter int WORDS_PER_GROUP = 4,
  parameter int NUM_GROUPS      = 32,
  parameter int ROM_LATENCY     = 1,
  localparam int DATA_WIDTH     = LANES_PER_WORD * WEIGHT_WIDTH,
  localparam int LANES          = LANES_PER_WORD * WORDS_PER_GROUP,
  localparam int GIDX_WIDTH     = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start_i,
  input  logic [ADDR_WIDTH-1:0]         base_addr_i,
  input  logic                          load_req_i,
  output logic                          rom_en_o,
  output logic [ADDR_WIDTH-1:0]         rom_addr_o,
  input  logic [DATA_WIDTH-1:0]         rom_data_i,
  output logic [LANES*WEIGHT_WIDTH-1:0] w_bus_o,
  output logic                          w_valid_o,
  input  logic                          w_ack_i,
  output logic [GIDX_WIDTH-1:0]         group_idx_o,
  output logic [NUM_GROUPS-1:0]         new_weight_val_o,
  output logic                          busy_o,
  output logic                          done_o
);

  localparam int KW = $clog2(WORDS_PER_GROUP + 1);

  typedef enum logic [2:0] {IDLE, READ, WAIT, VALID, DONE} state_e;

  state_e                        state_q;
  logic [ADDR_WIDTH-1:0]         base_q;
  logic [ADDR_WIDTH-1:0]         romAddr_q;
  logic [ADDR_WIDTH-1:0]         romAddr_d;
  logic [GIDX_WIDTH-1:0]         group_q;
  logic [KW-1:0]                 word_q;
  logic [KW-1:0]                 issueK_q;
  logic [KW-1:0]                 wordSel;
  logic                          romEn_q;
  logic                          wValid_q;
  logic                          busy_q;
  logic                          done_q;
  logic [LANES*WEIGHT_WIDTH-1:0] wBus_q;
  logic [NUM_GROUPS-1:0]         newWeightVal_q;
  logic [ROM_LATENCY-1:0]        capVld_q;
  logic [KW-1:0]                 capK_q [ROM_LATENCY];
  logic                          lastCapture;

  // The first word of a group is issued straight out of IDLE, later ones from the word counter.
  always_comb begin
    wordSel   = (state_q == IDLE) ? '0 : word_q;
    romAddr_d = base_q
              + ADDR_WIDTH'(group_q) * ADDR_WIDTH'(WORDS_PER_GROUP)
              + ADDR_WIDTH'(wordSel);
  end

  assign lastCapture = capVld_q[ROM_LATENCY-1]
                    && (capK_q[ROM_LATENCY-1] == KW'(WORDS_PER_GROUP - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      base_q         <= '0;
      romAddr_q      <= '0;
      group_q        <= '0;
      word_q         <= '0;
      issueK_q       <= '0;
      romEn_q        <= 1'b0;
      wValid_q       <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      wBus_q         <= '0;
      newWeightVal_q <= '0;
      capVld_q       <= '0;
      for (int i = 0; i < ROM_LATENCY; i++) capK_q[i] <= '0;
    end else if (start_i) begin
      // Restart drops any in-flight reads; the lane bus keeps its stale contents.
      state_q        <= IDLE;
      base_q         <= base_addr_i;
      group_q        <= '0;
      word_q         <= '0;
      romEn_q        <= 1'b0;
      wValid_q       <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      newWeightVal_q <= '0;
      capVld_q       <= '0;
    end else begin
      capVld_q[0] <= romEn_q;
      capK_q[0]   <= issueK_q;
      for (int i = 1; i < ROM_LATENCY; i++) begin
        capVld_q[i] <= capVld_q[i-1];
        capK_q[i]   <= capK_q[i-1];
      end

      // Word k fills lanes k*LANES_PER_WORD.. with its most significant weight first.
      if (capVld_q[ROM_LATENCY-1]) begin
        for (int j = 0; j < LANES_PER_WORD; j++) begin
          wBus_q[(int'(capK_q[ROM_LATENCY-1]) * LANES_PER_WORD + j) * WEIGHT_WIDTH +: WEIGHT_WIDTH]
            <= rom_data_i[(LANES_PER_WORD - 1 - j) * WEIGHT_WIDTH +: WEIGHT_WIDTH];
        end
      end

      case (state_q)
        IDLE: begin
          if (load_req_i) begin
            state_q   <= READ;
            romEn_q   <= 1'b1;
            romAddr_q <= romAddr_d;
            issueK_q  <= '0;
            word_q    <= KW'(1);
            busy_q    <= 1'b1;
          end
        end
        READ: begin
          if (word_q == KW'(WORDS_PER_GROUP)) begin
            state_q <= WAIT;
            romEn_q <= 1'b0;
            word_q  <= '0;
          end else begin
            romAddr_q <= romAddr_d;
            issueK_q  <= word_q;
            word_q    <= word_q + KW'(1);
          end
        end
        WAIT: begin
          if (lastCapture) begin
            state_q  <= VALID;
            wValid_q <= 1'b1;
            busy_q   <= 1'b0;
          end
        end
        VALID: begin
          if (w_ack_i) begin
            wValid_q       <= 1'b0;
            newWeightVal_q <= {newWeightVal_q[NUM_GROUPS-2:0], 1'b1};
            if (group_q == GIDX_WIDTH'(NUM_GROUPS - 1)) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= IDLE;
              group_q <= group_q + GIDX_WIDTH'(1);
            end
          end
        end
        DONE: begin
          state_q <= DONE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rom_en_o         = romEn_q;
  assign rom_addr_o       = romAddr_q;
  assign w_bus_o          = wBus_q;
  assign w_valid_o        = wValid_q;
  assign group_idx_o      = group_q;
  assign new_weight_val_o = newWeightVal_q;
  assign busy_o           = busy_q;
  assign done_o           = done_q;

endmodule

// File: tb/tb_weight_load_sched.sv
// Self-checking bench for weight_load_sched: directed vector table, hand-written
// corner sequences and randomized passes checked against a group-level ROM model.
module tb_weight_load_sched;

  localparam int AW      = 7;
  localparam int WW      = 7;
  localparam int LPW     = 4;
  localparam int WPG     = 4;
  localparam int NG      = 32;
  localparam int LAT     = 1;
  localparam int DW      = LPW * WW;
  localparam int NLANES  = LPW * WPG;
  localparam int ROMSIZE = 1 << AW;

  logic                 clk;
  logic                 rstN;
  logic                 start;
  logic [AW-1:0]        baseAddr;
  logic                 loadReq;
  logic                 romEn;
  logic [AW-1:0]        romAddr;
  logic [DW-1:0]        romData;
  logic [NLANES*WW-1:0] wBus;
  logic                 wValid;
  logic                 wAck;
  logic [4:0]           groupIdx;
  logic [NG-1:0]        nwv;
  logic                 busy;
  logic                 done;

  logic [DW-1:0] romMem [ROMSIZE];
  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic          start;
    logic [AW-1:0] base;
    logic          loadReq;
    logic          wAck;
    logic          expRomEn;
    logic [AW-1:0] expAddr;
    logic          expWValid;
    logic          expBusy;
    logic          expDone;
    logic [4:0]    expGroup;
  } vec_t;

  weight_load_sched dut (
    .clk              (clk),
    .rst_n            (rstN),
    .start_i          (start),
    .base_addr_i      (baseAddr),
    .load_req_i       (loadReq),
    .rom_en_o         (romEn),
    .rom_addr_o       (romAddr),
    .rom_data_i       (romData),
    .w_bus_o          (wBus),
    .w_valid_o        (wValid),
    .w_ack_i          (wAck),
    .group_idx_o      (groupIdx),
    .new_weight_val_o (nwv),
    .busy_o           (busy),
    .done_o           (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-cycle-latency ROM
  always @(posedge clk) if (romEn) romData <= romMem[romAddr];

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    start    = v.start;
    baseAddr = v.base;
    loadReq  = v.loadReq;
    wAck     = v.wAck;
    tick();
  endtask

  // Expected lane bus for group g of a pass starting at base, straight from the ROM image.
  function automatic logic [NLANES*WW-1:0] expBus(input int base, input int g);
    logic [NLANES*WW-1:0] b;
    logic [DW-1:0]        word;
    b = '0;
    for (int l = 0; l < NLANES; l++) begin
      word = romMem[(base + g * WPG + l / LPW) % ROMSIZE];
      b[l*WW +: WW] = word[(LPW - 1 - l % LPW) * WW +: WW];
    end
    return b;
  endfunction

  task automatic runGroup(input int base, input int g, input int ackDelay, input bit noise);
    int addrs[$];
    int cycles;
    int gap;
    logic [NLANES*WW-1:0] held;
    logic [63:0] expNwv;
    gap = noise ? $urandom_range(0, 2) : 0;
    for (int i = 0; i < gap; i++) begin
      loadReq = 1'b0;
      wAck    = 1'($urandom % 2);
      tick();
    end
    wAck = 1'b0;
    checkOutput($sformatf("g%0d_idx_before", g), groupIdx, g);
    loadReq = 1'b1;
    tick();
    cycles = 1;
    if (romEn) addrs.push_back(int'(romAddr));
    loadReq = 1'b0;
    while (!wValid && cycles < 20) begin
      if (noise) begin
        loadReq = 1'($urandom % 2);
        wAck    = 1'($urandom % 2);
      end
      tick();
      cycles++;
      if (romEn) addrs.push_back(int'(romAddr));
    end
    loadReq = 1'b0;
    wAck    = 1'b0;
    checkOutput($sformatf("g%0d_wvalid_rise", g), wValid, 1);
    if (!wValid) return;
    checkOutput($sformatf("g%0d_latency", g), cycles - 1, WPG + LAT);
    checkOutput($sformatf("g%0d_nreads", g), addrs.size(), WPG);
    for (int k = 0; k < addrs.size() && k < WPG; k++)
      checkOutput($sformatf("g%0d_addr%0d", g, k), addrs[k], (base + g * WPG + k) % ROMSIZE);
    checkOutput($sformatf("g%0d_wbus", g), wBus, expBus(base, g));
    held = wBus;
    for (int i = 0; i < ackDelay; i++) begin
      loadReq = noise ? 1'($urandom % 2) : 1'b0;
      tick();
    end
    loadReq = 1'b0;
    checkOutput($sformatf("g%0d_hold_valid", g), wValid, 1);
    checkOutput($sformatf("g%0d_hold_bus", g), wBus, held);
    wAck = 1'b1;
    tick();
    wAck = 1'b0;
    expNwv = (64'd1 << (g + 1)) - 64'd1;
    checkOutput($sformatf("g%0d_wvalid_drop", g), wValid, 0);
    checkOutput($sformatf("g%0d_nwv", g), nwv, expNwv[NG-1:0]);
    checkOutput($sformatf("g%0d_idx_after", g), groupIdx, (g == NG - 1) ? g : g + 1);
    checkOutput($sformatf("g%0d_done", g), done, (g == NG - 1) ? 1 : 0);
  endtask

  initial begin
    vec_t vecs[8];
    logic [NLANES*WW-1:0] lanePattern;
    int   enCount;
    int   validCount;
    int   nGroups;
    int   rbase;

    for (int n = 0; n < ROMSIZE; n++)
      romMem[n] = {7'(4 * n), 7'(4 * n + 1), 7'(4 * n + 2), 7'(4 * n + 3)};
    for (int k = 0; k < NLANES; k++) lanePattern[k*WW +: WW] = 7'(k);

    //              start base  lreq  ack   romEn addr  wv    busy  done  grp
    vecs[0] = '{1'b1, 7'd0, 1'b0, 1'b0, 1'b0, 7'd0, 1'b0, 1'b0, 1'b0, 5'd0};
    vecs[1] = '{1'b0, 7'd0, 1'b1, 1'b0, 1'b1, 7'd0, 1'b0, 1'b1, 1'b0, 5'd0};
    vecs[2] = '{1'b0, 7'd0, 1'b0, 1'b0, 1'b1, 7'd1, 1'b0, 1'b1, 1'b0, 5'd0};
    vecs[3] = '{1'b0, 7'd0, 1'b1, 1'b0, 1'b1, 7'd2, 1'b0, 1'b1, 1'b0, 5'd0};
    vecs[4] = '{1'b0, 7'd0, 1'b0, 1'b1, 1'b1, 7'd3, 1'b0, 1'b1, 1'b0, 5'd0};
    vecs[5] = '{1'b0, 7'd0, 1'b0, 1'b0, 1'b0, 7'd0, 1'b0, 1'b1, 1'b0, 5'd0};
    vecs[6] = '{1'b0, 7'd0, 1'b0, 1'b0, 1'b0, 7'd0, 1'b1, 1'b0, 1'b0, 5'd0};
    vecs[7] = '{1'b0, 7'd0, 1'b1, 1'b0, 1'b0, 7'd0, 1'b1, 1'b0, 1'b0, 5'd0};

    rstN = 1'b0; start = 1'b0; baseAddr = '0; loadReq = 1'b0; wAck = 1'b0;
    tick();
    tick();
    checkOutput("rst_romEn", romEn, 0);
    checkOutput("rst_romAddr", romAddr, 0);
    checkOutput("rst_wBus", wBus, 0);
    checkOutput("rst_wValid", wValid, 0);
    checkOutput("rst_group", groupIdx, 0);
    checkOutput("rst_nwv", nwv, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    rstN = 1'b1;

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("v%0d_romEn", i), romEn, vecs[i].expRomEn);
      if (vecs[i].expRomEn) checkOutput($sformatf("v%0d_romAddr", i), romAddr, vecs[i].expAddr);
      checkOutput($sformatf("v%0d_wValid", i), wValid, vecs[i].expWValid);
      checkOutput($sformatf("v%0d_busy", i), busy, vecs[i].expBusy);
      checkOutput($sformatf("v%0d_done", i), done, vecs[i].expDone);
      checkOutput($sformatf("v%0d_group", i), groupIdx, vecs[i].expGroup);
    end
    checkOutput("first_lanes", wBus, lanePattern);

    // Hold off the ack: the group must sit still, stray load_req notwithstanding.
    loadReq = 1'b0; wAck = 1'b0;
    for (int i = 0; i < 10; i++) begin
      loadReq = 1'(i % 2);
      tick();
      checkOutput($sformatf("hold%0d_wValid", i), wValid, 1);
      checkOutput($sformatf("hold%0d_wBus", i), wBus, lanePattern);
    end
    loadReq = 1'b0;
    wAck = 1'b1;
    tick();
    wAck = 1'b0;
    checkOutput("ack_wValid", wValid, 0);
    checkOutput("ack_group", groupIdx, 1);
    checkOutput("ack_nwv", nwv, 1);
    wAck = 1'b1;
    tick();
    wAck = 1'b0;
    checkOutput("stray_ack_group", groupIdx, 1);
    checkOutput("stray_ack_nwv", nwv, 1);

    $display("[TB] full pass from base 0");
    start = 1'b1; baseAddr = 7'd0;
    tick();
    start = 1'b0;
    checkOutput("restart_group", groupIdx, 0);
    checkOutput("restart_nwv", nwv, 0);
    for (int g = 0; g < NG; g++) runGroup(0, g, $urandom_range(0, 2), 1'b1);
    checkOutput("pass_nwv", nwv, 32'hFFFF_FFFF);
    checkOutput("pass_done", done, 1);
    loadReq = 1'b1;
    tick();
    loadReq = 1'b0;
    enCount = 0;
    for (int i = 0; i < 8; i++) begin
      if (romEn) enCount++;
      tick();
    end
    checkOutput("done_no_read", enCount, 0);
    checkOutput("done_sticky", done, 1);

    $display("[TB] address wrap");
    start = 1'b1; baseAddr = 7'd126;
    tick();
    start = 1'b0;
    checkOutput("wrap_done_clear", done, 0);
    runGroup(126, 0, 1, 1'b0);

    $display("[TB] restart in the middle of a read");
    start = 1'b1; baseAddr = 7'd10;
    tick();
    start = 1'b0; loadReq = 1'b1;
    tick();
    loadReq = 1'b0;
    checkOutput("mid_addr0", romAddr, 10);
    tick();
    tick();
    checkOutput("mid_addr2", romAddr, 12);
    start = 1'b1; baseAddr = 7'd50; loadReq = 1'b1; wAck = 1'b1;
    tick();
    start = 1'b0; loadReq = 1'b0; wAck = 1'b0;
    checkOutput("mid_romEn_drop", romEn, 0);
    checkOutput("mid_busy_drop", busy, 0);
    validCount = 0;
    enCount = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (wValid) validCount++;
      if (romEn) enCount++;
    end
    checkOutput("mid_no_valid", validCount, 0);
    checkOutput("mid_no_read", enCount, 0);
    runGroup(50, 0, 0, 1'b0);

    $display("[TB] asynchronous reset during a read");
    start = 1'b1; baseAddr = 7'd0;
    tick();
    start = 1'b0; loadReq = 1'b1;
    tick();
    loadReq = 1'b0;
    tick();
    #2 rstN = 1'b0;
    #1;
    checkOutput("arst_romEn", romEn, 0);
    checkOutput("arst_busy", busy, 0);
    checkOutput("arst_romAddr", romAddr, 0);
    tick();
    rstN = 1'b1;
    enCount = 0;
    validCount = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (romEn) enCount++;
      if (wValid) validCount++;
    end
    checkOutput("arst_no_read", enCount, 0);
    checkOutput("arst_no_valid", validCount, 0);

    $display("[TB] randomized passes");
    for (int p = 0; p < 3; p++) begin
      for (int n = 0; n < ROMSIZE; n++) romMem[n] = DW'($urandom);
      rbase   = $urandom_range(0, ROMSIZE - 1);
      nGroups = $urandom_range(3, 6);
      start = 1'b1; baseAddr = AW'(rbase);
      tick();
      start = 1'b0;
      for (int g = 0; g < nGroups; g++) runGroup(rbase, g, $urandom_range(0, 3), 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
